// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit_if
// Brief    : Issue/result bundle between the execute stage and mul_div_unit.
// Revision : 1.0  initial release
// ============================================================================
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative 32-bit mult/multu/div/divu plus mthi/mtlo, owning HI/LO.
// Revision : 1.0  initial release
// ============================================================================
module mul_div_unit (
    input  wire logic      clk,
    input  wire logic      rst,
    mul_div_unit_if.slave  bus
);
    localparam logic [2:0] C_OP_MULT  = 3'd0;
    localparam logic [2:0] C_OP_MULTU = 3'd1;
    localparam logic [2:0] C_OP_DIV   = 3'd2;
    localparam logic [2:0] C_OP_DIVU  = 3'd3;
    localparam logic [2:0] C_OP_MTHI  = 3'd4;
    localparam logic [2:0] C_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_acc;      // P_hi for multiply, partial remainder for divide
    logic [31:0] r_q;        // P_lo for multiply, quotient for divide
    logic [31:0] r_opnd;     // multiplicand or divisor magnitude
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_a;
    logic        r_busy;
    logic        r_done;
    logic        r_dbz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_shift_r;
    logic [32:0] w_trial;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    always_comb begin
        w_signed   = (bus.op == C_OP_MULT) || (bus.op == C_OP_DIV);
        w_abs_a    = (w_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
        w_abs_b    = (w_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
        w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : 33'd0);
        w_shift_r  = {r_acc, r_q[31]};
        w_trial    = w_shift_r - {1'b0, r_opnd};
        w_prod     = {r_acc, r_q};
        w_prod_fix = r_neg_res ? (64'd0 - w_prod) : w_prod;
        w_quo_fix  = r_neg_res ? (32'd0 - r_q) : r_q;
        w_rem_fix  = r_neg_a ? (32'd0 - r_acc) : r_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_acc     <= 32'd0;
            r_q       <= 32'd0;
            r_opnd    <= 32'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_a   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            C_OP_MTHI: begin
                                r_hi   <= bus.a;
                                r_dbz  <= 1'b0;
                                r_done <= 1'b1;
                            end
                            C_OP_MTLO: begin
                                r_lo   <= bus.a;
                                r_dbz  <= 1'b0;
                                r_done <= 1'b1;
                            end
                            C_OP_MULT, C_OP_MULTU: begin
                                r_acc     <= 32'd0;
                                r_q       <= w_abs_b;
                                r_opnd    <= w_abs_a;
                                r_is_div  <= 1'b0;
                                r_neg_res <= w_signed && (bus.a[31] ^ bus.b[31]);
                                r_neg_a   <= w_signed && bus.a[31];
                                r_cnt     <= 5'd0;
                                r_dbz     <= 1'b0;
                                r_busy    <= 1'b1;
                                r_state   <= S_RUN;
                            end
                            C_OP_DIV, C_OP_DIVU: begin
                                if (bus.b == 32'd0) begin
                                    // Zero divisor: flag it and leave HI/LO untouched
                                    r_dbz  <= 1'b1;
                                    r_done <= 1'b1;
                                end else begin
                                    r_acc     <= 32'd0;
                                    r_q       <= w_abs_a;
                                    r_opnd    <= w_abs_b;
                                    r_is_div  <= 1'b1;
                                    r_neg_res <= w_signed && (bus.a[31] ^ bus.b[31]);
                                    r_neg_a   <= w_signed && bus.a[31];
                                    r_cnt     <= 5'd0;
                                    r_dbz     <= 1'b0;
                                    r_busy    <= 1'b1;
                                    r_state   <= S_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        // Non-negative trial keeps the difference; otherwise restore
                        if (!w_trial[32]) begin
                            r_acc <= w_trial[31:0];
                            r_q   <= {r_q[30:0], 1'b1};
                        end else begin
                            r_acc <= w_shift_r[31:0];
                            r_q   <= {r_q[30:0], 1'b0};
                        end
                    end else begin
                        r_acc <= w_mul_sum[32:1];
                        r_q   <= {w_mul_sum[0], r_q[31:1]};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_lo <= w_quo_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Directed self-checking bench for mul_div_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 32'hA5A5_A5A5;
        bus.b     = 32'h5A5A_5A5A;
    endtask

    // exp_edges: negedges after accept until done, equal to busy-high cycles
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_edges,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n = 0;
        int nbusy = 0;
        issue(op, a, b);
        while (!bus.done && n < 100) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            n++;
        end
        check({tag, "_done_at"}, n, exp_edges);
        check({tag, "_busy_cycles"}, nbusy, exp_edges);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
        @(negedge clk);
        check({tag, "_done_pulse"}, {bus.done, bus.busy}, 2'b00);
    endtask

    initial begin
        int ndone;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_flags", {bus.busy, bus.done, bus.div_by_zero}, 3'b000);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;

        run_op("mult_neg3x7",   3'd0, 32'hFFFF_FFFD, 32'd7, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_ones",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_ones",     3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0, 32'h1);
        run_op("div_neg7by2",   3'd2, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100by7",   3'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("div_ovf",       3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
        run_op("mthi",          3'd4, 32'h0000_1234, 32'd0, 0, 32'h0000_1234, 32'h8000_0000);
        run_op("mtlo",          3'd5, 32'h0000_5678, 32'd0, 0, 32'h0000_1234, 32'h0000_5678);
        check("dbz_before", bus.div_by_zero, 1'b0);
        run_op("divu_by0",      3'd3, 32'd5, 32'd0, 0, 32'h0000_1234, 32'h0000_5678);
        check("dbz_set", bus.div_by_zero, 1'b1);

        // Reserved op must not touch anything, including the sticky flag
        issue(3'd6, 32'hFFFF_FFFF, 32'd1);
        check("reserved_nodone", {bus.done, bus.busy, bus.div_by_zero}, 3'b001);

        // Mult with stray starts at cycles 5 and 20; only the mult result appears
        issue(3'd0, 32'h4000_0001, 32'd8);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5 || i == 20) begin
                bus.start = 1'b1;
                bus.op    = 3'd4;
                bus.a     = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) ndone++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("ignore_done_count", ndone, 1);
        check("ignore_hi", bus.hi, 32'h2);
        check("ignore_lo", bus.lo, 32'h8);
        check("dbz_cleared", bus.div_by_zero, 1'b0);

        // Asynchronous reset in the middle of a divu
        issue(3'd3, 32'd1000, 32'd3);
        repeat (16) @(negedge clk);
        check("midop_busy", bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_flags", {bus.busy, bus.done}, 2'b00);
        check("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("mult_after_rst", 3'd0, 32'h0001_0000, 32'h0001_0000, 33, 32'h1, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the MIPS datapath, sitting beside the combinational ALU in the execute stage. It implements mult, multu, div, divu, mthi and mtlo, and owns the HI/LO architectural registers. The pipeline issues work through a start/busy/done handshake and stalls on busy. One operand bit is processed per cycle.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  issue request; sampled on a rising edge only while busy=0.
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are reserved.
- a  input  32  rs operand: multiplicand, dividend, or mthi/mtlo data.
- b  input  32  rt operand: multiplier or divisor.
- busy  output  1  high while an iterative op is in progress.
- done  output  1  one-cycle pulse when HI/LO (or the error flag) has just been updated.
- div_by_zero  output  1  registered; set by div/divu with b=0, cleared by the next accepted op.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- States:
  - IDLE: accepts start.
  - RUN: 32 iterations, 5-bit counter 0..31.
  - FIX: sign correction and HI/LO write.
- Reset drives the state to IDLE and sets busy, done, div_by_zero, hi, lo, the counter and all internal accumulators to 0.
- Operands are latched on the accepting edge; a and b may change afterwards.
- mult/div (signed): operate on magnitudes |a| and |b|; record the sign flags at accept.
- multu/divu: operate on raw values; sign flags are 0.
- Multiply:
  - 64-bit product register {P_hi, P_lo}, with P_lo initialised to the multiplier magnitude.
  - Each RUN cycle: if P_lo[0] is set, add the multiplicand into P_hi with a 33-bit carry, then shift the whole register right 1.
  - FIX: negate the 64-bit product if the operand signs differ; write hi=product[63:32] and lo=product[31:0].
- Divide (restoring):
  - 33-bit partial remainder R and 32-bit quotient Q, with Q initialised to the dividend magnitude.
  - Each RUN cycle: shift {R,Q} left 1, then trial-subtract the divisor from R.
  - If the trial result is non-negative, keep it and set Q[0]=1; otherwise restore R and set Q[0]=0.
  - FIX: the quotient truncates toward zero, so negate Q if the operand signs differ; the remainder takes the dividend's sign, so negate R if a was negative.
  - FIX writes lo=quotient and hi=remainder.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0; no trap.
- Divide by zero: no RUN. div_by_zero=1 and done=1 on the cycle after accept; hi/lo unchanged; state stays IDLE.
- mthi/mtlo: write hi=a or lo=a on the accepting edge; done=1 the next cycle; busy never asserts.
- Reserved op with start: ignored entirely; no done and no state change.
- start while busy=1: ignored and not queued. The issuer must hold or replay it.
- Reset mid-operation: the op is aborted immediately and hi/lo return to 0.

## Timing
- Edge E0 accepts an iterative op (start=1, busy=0, valid op).
- busy=1 from just after E0 through E33 (RUN covers E1..E32, FIX ends at E33).
- hi/lo update at E33. done=1 and busy=0 in the cycle following E33, so the latency from accept to done is 33 cycles.
- A new start may be accepted at the edge that ends the done cycle (E34).
- hi/lo hold their old values throughout RUN. Intermediate results are never visible.
- mthi/mtlo and divide-by-zero take one cycle from accept to done. Back-to-back issue is allowed on consecutive cycles.
- All outputs are registered; none depends combinationally on start, op, a or b.

## Test plan
- mult a=0xFFFFFFFD (-3), b=7 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once, busy high exactly 33 cycles.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; mult on the same operands -> hi=0, lo=1.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100/7 -> lo=14, hi=2; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=5, b=0 after mthi 0x1234 and mtlo 0x5678 -> one cycle later div_by_zero=1, done=1, hi=0x1234, lo=0x5678. A following mult clears div_by_zero.
- start with a different op pulsed at cycles 5 and 20 during a mult -> ignored; only the original result appears and only one done is seen.
- rst asserted asynchronously mid-clock at iteration 16 of a divu -> busy, done, hi and lo go to 0 immediately. After release, a new mult completes correctly in 33 cycles.
